// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, ID/EX register layout and source-usage helpers
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [REGW-1:0] rs1;
      logic [REGW-1:0] rs2;
      logic [REGW-1:0] rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            is_load;
      logic            valid;
   } id_ex_t;

   function automatic logic uses_rs1(input logic [6:0] opcode);
      return (opcode == OP_REG) || (opcode == OP_IMM) || (opcode == OP_LOAD) ||
             (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_JALR);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   endfunction

endpackage

// File: rtl/imm_extend.sv
// rtl/imm_extend.sv - combinational RV32I immediate decode with sign extension
module imm_extend
   import riscv_pkg::*;
(
   input  logic [31:7] instr,
   input  logic [6:0]  opcode,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR:
            imm = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {instr[31:12], 12'b0};
         OP_JAL:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: IF/ID and ID/EX registers, load-use hazard stall
module decode_stage
   import riscv_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr_f,
   input  logic [DATAWIDTH-1:0] pc_f,
   input  logic [DATAWIDTH-1:0] pc_plus4_f,
   input  logic                 valid_f,
   input  logic                 flush,
   output logic [ADDRWIDTH-1:0] rs1_d,
   output logic [ADDRWIDTH-1:0] rs2_d,
   input  logic [DATAWIDTH-1:0] rd1_d,
   input  logic [DATAWIDTH-1:0] rd2_d,
   output logic                 stall_f,
   output logic [DATAWIDTH-1:0] rd1_e,
   output logic [DATAWIDTH-1:0] rd2_e,
   output logic [DATAWIDTH-1:0] imm_e,
   output logic [DATAWIDTH-1:0] pc_e,
   output logic [DATAWIDTH-1:0] pc_plus4_e,
   output logic [ADDRWIDTH-1:0] rs1_e,
   output logic [ADDRWIDTH-1:0] rs2_e,
   output logic [ADDRWIDTH-1:0] rd_e,
   output logic [6:0]           opcode_e,
   output logic [2:0]           funct3_e,
   output logic                 funct7b5_e,
   output logic                 is_load_e,
   output logic                 valid_e,
   output logic [31:0]          stall_count
);

   logic [31:0]          instr_d;
   logic [DATAWIDTH-1:0] pc_d;
   logic [DATAWIDTH-1:0] pc_plus4_d;
   logic                 valid_d;
   id_ex_t               ex_q;
   id_ex_t               ex_next;
   logic [31:0]          stall_cnt_q;

   logic [6:0]           opcode_d;
   logic [ADDRWIDTH-1:0] rd_d;
   logic [31:0]          imm_d;
   logic                 hz;

   assign opcode_d = instr_d[6:0];
   assign rs1_d    = instr_d[19:15];
   assign rs2_d    = instr_d[24:20];
   assign rd_d     = instr_d[11:7];

   imm_extend u_imm_extend (
      .instr  (instr_d[31:7]),
      .opcode (opcode_d),
      .imm    (imm_d)
   );

   // Only a valid load with a nonzero destination can block a consumer in decode.
   assign hz = valid_d && ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
               ((uses_rs1(opcode_d) && (rs1_d == ex_q.rd)) ||
                (uses_rs2(opcode_d) && (rs2_d == ex_q.rd)));

   assign stall_f = hz && !flush;

   always_comb begin
      ex_next          = '0;
      ex_next.rd1      = rd1_d;
      ex_next.rd2      = rd2_d;
      ex_next.imm      = imm_d;
      ex_next.pc       = pc_d;
      ex_next.pc_plus4 = pc_plus4_d;
      ex_next.rs1      = rs1_d;
      ex_next.rs2      = rs2_d;
      ex_next.rd       = valid_d ? rd_d : '0;
      ex_next.opcode   = opcode_d;
      ex_next.funct3   = instr_d[14:12];
      ex_next.funct7b5 = instr_d[30];
      ex_next.is_load  = valid_d && (opcode_d == OP_LOAD);
      ex_next.valid    = valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_d     <= '0;
         pc_d        <= '0;
         pc_plus4_d  <= '0;
         valid_d     <= 1'b0;
         ex_q        <= '0;
         stall_cnt_q <= '0;
      end else if (flush) begin
         instr_d     <= '0;
         pc_d        <= '0;
         pc_plus4_d  <= '0;
         valid_d     <= 1'b0;
         ex_q        <= '0;
      end else if (hz) begin
         // IF/ID holds the consumer; execute gets an all-zero bubble.
         ex_q <= '0;
         if (stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end else begin
         instr_d    <= instr_f;
         pc_d       <= pc_f;
         pc_plus4_d <= pc_plus4_f;
         valid_d    <= valid_f;
         ex_q       <= ex_next;
      end
   end

   assign rd1_e       = ex_q.rd1;
   assign rd2_e       = ex_q.rd2;
   assign imm_e       = ex_q.imm;
   assign pc_e        = ex_q.pc;
   assign pc_plus4_e  = ex_q.pc_plus4;
   assign rs1_e       = ex_q.rs1;
   assign rs2_e       = ex_q.rs2;
   assign rd_e        = ex_q.rd;
   assign opcode_e    = ex_q.opcode;
   assign funct3_e    = ex_q.funct3;
   assign funct7b5_e  = ex_q.funct7b5;
   assign is_load_e   = ex_q.is_load;
   assign valid_e     = ex_q.valid;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_f;
   logic [31:0] pc_f;
   logic [31:0] pc_plus4_f;
   logic        valid_f;
   logic        flush;
   logic [4:0]  rs1_d;
   logic [4:0]  rs2_d;
   logic [31:0] rd1_d;
   logic [31:0] rd2_d;
   logic        stall_f;
   logic [31:0] rd1_e;
   logic [31:0] rd2_e;
   logic [31:0] imm_e;
   logic [31:0] pc_e;
   logic [31:0] pc_plus4_e;
   logic [4:0]  rs1_e;
   logic [4:0]  rs2_e;
   logic [4:0]  rd_e;
   logic [6:0]  opcode_e;
   logic [2:0]  funct3_e;
   logic        funct7b5_e;
   logic        is_load_e;
   logic        valid_e;
   logic [31:0] stall_count;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [31:0] I_ADDI   = 32'hFFF0_0293; // addi x5,x0,-1
   localparam logic [31:0] I_LW6    = 32'h0001_2303; // lw   x6,0(x2)
   localparam logic [31:0] I_ADD761 = 32'h0013_03B3; // add  x7,x6,x1
   localparam logic [31:0] I_LW0    = 32'h0001_2003; // lw   x0,0(x2)
   localparam logic [31:0] I_ADD701 = 32'h0010_03B3; // add  x7,x0,x1
   localparam logic [31:0] I_LUI6   = 32'h0003_0337; // lui  x6,0x30 (rs1 field happens to be 6)
   localparam logic [31:0] I_BEQ    = 32'hFE20_8CE3; // beq  x1,x2,-8
   localparam logic [31:0] I_JAL    = 32'h0010_00EF; // jal  x1,2048
   localparam logic [31:0] I_SW     = 32'hFE51_2E23; // sw   x5,-4(x2)

   always #5 clk = ~clk;

   decode_stage #(.DATAWIDTH(32), .ADDRWIDTH(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_f     (instr_f),
      .pc_f        (pc_f),
      .pc_plus4_f  (pc_plus4_f),
      .valid_f     (valid_f),
      .flush       (flush),
      .rs1_d       (rs1_d),
      .rs2_d       (rs2_d),
      .rd1_d       (rd1_d),
      .rd2_d       (rd2_d),
      .stall_f     (stall_f),
      .rd1_e       (rd1_e),
      .rd2_e       (rd2_e),
      .imm_e       (imm_e),
      .pc_e        (pc_e),
      .pc_plus4_e  (pc_plus4_e),
      .rs1_e       (rs1_e),
      .rs2_e       (rs2_e),
      .rd_e        (rd_e),
      .opcode_e    (opcode_e),
      .funct3_e    (funct3_e),
      .funct7b5_e  (funct7b5_e),
      .is_load_e   (is_load_e),
      .valid_e     (valid_e),
      .stall_count (stall_count)
   );

   task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] instr, input logic [31:0] pc, input logic v);
      instr_f    = instr;
      pc_f       = pc;
      pc_plus4_f = pc + 32'd4;
      valid_f    = v;
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      rd1_d = '0;
      rd2_d = '0;
      fetch(32'h0, 32'h0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      expect_eq("rst_valid_e", {31'b0, valid_e}, 32'd0);
      expect_eq("rst_stall_count", stall_count, 32'd0);
      expect_eq("rst_stall_f", {31'b0, stall_f}, 32'd0);
      expect_eq("rst_imm_e", imm_e, 32'd0);

      // addi reaches execute two edges after fetch
      fetch(I_ADDI, 32'h100, 1'b1);
      tick();
      expect_eq("addi_rs1_d", {27'b0, rs1_d}, 32'd0);
      rd1_d = 32'h1111_2222;
      fetch(32'h0, 32'h0, 1'b0);
      tick();
      expect_eq("addi_valid_e", {31'b0, valid_e}, 32'd1);
      expect_eq("addi_imm_e", imm_e, 32'hFFFF_FFFF);
      expect_eq("addi_rd_e", {27'b0, rd_e}, 32'd5);
      expect_eq("addi_opcode_e", {25'b0, opcode_e}, 32'h13);
      expect_eq("addi_pc_e", pc_e, 32'h100);
      expect_eq("addi_pc_plus4_e", pc_plus4_e, 32'h104);
      expect_eq("addi_rd1_e", rd1_e, 32'h1111_2222);

      // load-use: one stall cycle, one bubble
      fetch(I_LW6, 32'h200, 1'b1);
      tick();
      fetch(I_ADD761, 32'h204, 1'b1);
      tick();
      expect_eq("lu_is_load_e", {31'b0, is_load_e}, 32'd1);
      expect_eq("lu_stall_f", {31'b0, stall_f}, 32'd1);
      fetch(32'h0, 32'h0, 1'b0);
      tick();
      expect_eq("lu_bubble_valid_e", {31'b0, valid_e}, 32'd0);
      expect_eq("lu_bubble_rd_e", {27'b0, rd_e}, 32'd0);
      expect_eq("lu_bubble_is_load", {31'b0, is_load_e}, 32'd0);
      expect_eq("lu_stall_f_clear", {31'b0, stall_f}, 32'd0);
      expect_eq("lu_stall_count", stall_count, 32'd1);
      expect_eq("lu_ifid_hold_rs1", {27'b0, rs1_d}, 32'd6);
      rd1_d = 32'hCAFE_0006;
      tick();
      expect_eq("lu_add_valid_e", {31'b0, valid_e}, 32'd1);
      expect_eq("lu_add_rd_e", {27'b0, rd_e}, 32'd7);
      expect_eq("lu_add_rs1_e", {27'b0, rs1_e}, 32'd6);
      expect_eq("lu_add_rs2_e", {27'b0, rs2_e}, 32'd1);
      expect_eq("lu_add_pc_e", pc_e, 32'h204);
      expect_eq("lu_add_opcode_e", {25'b0, opcode_e}, 32'h33);
      expect_eq("lu_add_rd1_e", rd1_e, 32'hCAFE_0006);

      // lw to x0 never stalls
      fetch(I_LW0, 32'h220, 1'b1);
      tick();
      fetch(I_ADD701, 32'h224, 1'b1);
      tick();
      expect_eq("x0_is_load_e", {31'b0, is_load_e}, 32'd1);
      expect_eq("x0_rd_e", {27'b0, rd_e}, 32'd0);
      expect_eq("x0_stall_f", {31'b0, stall_f}, 32'd0);
      fetch(32'h0, 32'h0, 1'b0);
      tick();
      expect_eq("x0_add_valid_e", {31'b0, valid_e}, 32'd1);
      expect_eq("x0_add_rd_e", {27'b0, rd_e}, 32'd7);

      // lui does not read rs1, even when its field matches rd_e
      fetch(I_LW6, 32'h240, 1'b1);
      tick();
      fetch(I_LUI6, 32'h244, 1'b1);
      tick();
      expect_eq("lui_rs1_field", {27'b0, rs1_d}, 32'd6);
      expect_eq("lui_stall_f", {31'b0, stall_f}, 32'd0);
      fetch(32'h0, 32'h0, 1'b0);
      tick();
      expect_eq("lui_valid_e", {31'b0, valid_e}, 32'd1);
      expect_eq("lui_opcode_e", {25'b0, opcode_e}, 32'h37);
      expect_eq("lui_imm_e", imm_e, 32'h0003_0000);
      expect_eq("lui_stall_count", stall_count, 32'd1);

      // flush beats a simultaneous hazard
      fetch(I_LW6, 32'h260, 1'b1);
      tick();
      fetch(I_ADD761, 32'h264, 1'b1);
      tick();
      flush = 1'b1;
      fetch(32'h0, 32'h0, 1'b0);
      #1;
      expect_eq("fl_stall_f", {31'b0, stall_f}, 32'd0);
      tick();
      flush = 1'b0;
      expect_eq("fl_valid_e", {31'b0, valid_e}, 32'd0);
      expect_eq("fl_stall_count", stall_count, 32'd1);
      expect_eq("fl_rs1_d", {27'b0, rs1_d}, 32'd0);
      tick();
      expect_eq("fl_valid_d_killed", {31'b0, valid_e}, 32'd0);

      // B-, J- and S-type immediates back to back
      fetch(I_BEQ, 32'h300, 1'b1);
      tick();
      fetch(I_JAL, 32'h304, 1'b1);
      tick();
      expect_eq("beq_imm_e", imm_e, 32'hFFFF_FFF8);
      expect_eq("beq_opcode_e", {25'b0, opcode_e}, 32'h63);
      fetch(I_SW, 32'h308, 1'b1);
      tick();
      expect_eq("jal_imm_e", imm_e, 32'h0000_0800);
      expect_eq("jal_pc_e", pc_e, 32'h304);
      fetch(32'h0, 32'h0, 1'b0);
      tick();
      expect_eq("sw_imm_e", imm_e, 32'hFFFF_FFFC);
      expect_eq("sw_funct3_e", {29'b0, funct3_e}, 32'd2);
      expect_eq("sw_rd_e_field", {27'b0, rd_e}, 32'h1C);

      // counter saturates
      dut.stall_cnt_q = 32'hFFFF_FFFF;
      fetch(I_LW6, 32'h400, 1'b1);
      tick();
      fetch(I_ADD761, 32'h404, 1'b1);
      tick();
      expect_eq("sat_stall_f", {31'b0, stall_f}, 32'd1);
      fetch(32'h0, 32'h0, 1'b0);
      tick();
      expect_eq("sat_stall_count", stall_count, 32'hFFFF_FFFF);
      expect_eq("sat_bubble_valid_e", {31'b0, valid_e}, 32'd0);
      tick();
      expect_eq("sat_add_valid_e", {31'b0, valid_e}, 32'd1);

      // reset in the middle of a stall
      fetch(I_LW6, 32'h500, 1'b1);
      tick();
      fetch(I_ADD761, 32'h504, 1'b1);
      tick();
      expect_eq("rs_stall_f_pre", {31'b0, stall_f}, 32'd1);
      rst = 1'b1;
      fetch(32'h0, 32'h0, 1'b0);
      tick();
      expect_eq("rs_valid_e", {31'b0, valid_e}, 32'd0);
      expect_eq("rs_stall_count", stall_count, 32'd0);
      expect_eq("rs_stall_f", {31'b0, stall_f}, 32'd0);
      expect_eq("rs_pc_e", pc_e, 32'd0);
      expect_eq("rs_rs1_d", {27'b0, rs1_d}, 32'd0);
      rst = 1'b0;
      tick();
      expect_eq("rs_after_valid_e", {31'b0, valid_e}, 32'd0);
      expect_eq("rs_after_stall_count", stall_count, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the pipelined RV32I core. It holds the IF/ID pipeline register and drives the register-file read addresses. It extracts instruction fields and sign-extends the immediate, detects load-use hazards against the instruction in execute, and holds the ID/EX pipeline register that the execute stage consumes. Register-file read data is captured here; the file's negedge write makes writeback-to-decode forwarding unnecessary.

## Interface
- DATAWIDTH, 32, data/PC width
- ADDRWIDTH, 5, register address width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- instr_f  in  32  fetched instruction
- pc_f, pc_plus4_f  in  DATAWIDTH  fetch PC and PC+4
- valid_f  in  1  fetch slot holds a real instruction
- flush  in  1  branch/jump taken in execute; kill decode and execute slots
- rs1_d, rs2_d  out  ADDRWIDTH  register-file read addresses (combinational from IF/ID)
- rd1_d, rd2_d  in  DATAWIDTH  register-file read data
- stall_f  out  1  hold the fetch PC (load-use hazard)
- rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e  out  DATAWIDTH  ID/EX data
- rs1_e, rs2_e, rd_e  out  ADDRWIDTH  ID/EX register addresses (for forwarding)
- opcode_e  out  7; funct3_e  out  3; funct7b5_e  out  1  fields for the control unit
- is_load_e, valid_e  out  1  execute slot is a load / is valid
- stall_count  out  32  saturating count of load-use stall cycles

## Operation
- IF/ID register fields: instr_d, pc_d, pc_plus4_d, valid_d.
- Combinational field extraction from instr_d:
  - rs1_d = [19:15], rs2_d = [24:20], rd_d = [11:7], opcode = [6:0].
- Immediate by opcode, sign-extended from bit 31; any other opcode gives 0:
  - I-type (0000011, 0010011, 1100111): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Source usage:
  - uses_rs1 for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for opcodes 0110011, 0100011, 1100011.
- Hazard: hz = valid_d & valid_e & is_load_e & (rd_e != 0) & ((uses_rs1 & rs1_d == rd_e) | (uses_rs2 & rs2_d == rd_e)).
- stall_f = hz & ~flush.
- Next-state, highest priority first:
  - rst: all registers 0 and stall_count 0.
  - flush: valid_d←0 and valid_e←0; the remaining fields are don't-care but are zeroed; stall_count unchanged.
  - hz: IF/ID holds; ID/EX becomes a bubble (valid_e, is_load_e, rd_e ← 0); stall_count increments, saturating at 0xFFFF_FFFF.
  - otherwise: IF/ID ← fetch inputs; ID/EX ← decoded fields, rd1_d/rd2_d and the immediate, with valid_e ← valid_d.
- An invalid decode slot (valid_d = 0) propagates with valid_e = 0 and rd_e forced to 0.
- is_load_e ← valid_d & (opcode == 0000011).

## Timing
- Decode-to-execute latency is 1 cycle; fetch-to-execute is 2 cycles absent stalls.
- A load-use stall lasts exactly 1 cycle: after the bubble, is_load_e = 0, so hz deasserts.
- A register-file write on the negedge of cycle N is visible on rd1_d/rd2_d before posedge N+1, so no internal bypass exists.
- stall_f is combinational in the same cycle as hz.
- Simultaneous flush and hz: flush wins; no stall is counted and stall_f = 0.
- Reset asserted mid-stall: all slots are invalid on the next edge, with no residual stall.

## Structure
- Shared package riscv_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_IMM, OP_REG).
  - typedef id_ex_t, a packed struct of the ID/EX fields.
- Sub-module imm_extend: purely combinational, takes instr[31:7] and the opcode, returns the 32-bit immediate.

## Test plan
- After reset, drive addi x5,x0,-1 (0xFFF00293) with valid_f=1 → two edges later valid_e=1, imm_e=0xFFFFFFFF, rd_e=5, opcode_e=0010011.
- Drive lw x6,0(x2) then add x7,x6,x1 → stall_f=1 for one cycle, one bubble (valid_e=0), add reaches execute one cycle late, stall_count=1.
- Drive lw x0,0(x2) then add x7,x0,x1 → no stall; repeat with lui x6 after lw x6 → no stall (rs unused).
- Assert flush in the cycle a load-use hazard is present → stall_f=0, valid_d=valid_e=0 next edge, stall_count unchanged.
- Drive beq x1,x2,-8 (0xFE208CE3) and jal x1,2048 (0x001000EF) → imm_e=0xFFFFFFF8, then imm_e=0x00000800.
- Force stall_count to saturate (preload via backdoor to 0xFFFFFFFF) then stall → remains 0xFFFFFFFF; assert rst during a stall → all outputs 0 next edge.
